// File: rtl/if_id_queue.sv
// Fetch-to-decode buffer: DEPTH-entry in-order queue of {inst, pc} with flush and PC+4.
// Optional performance counters are built when IF_ID_QUEUE_PERF_EN is defined.
module if_id_queue #(
  parameter int          DEPTH      = 2,
  parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [31:0]                in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_pc4,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef IF_ID_QUEUE_PERF_EN
  ,
  output logic [15:0]                stall_cycles,
  output logic [15:0]                flush_drops
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_inc;
  logic          push;
  logic          pop;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // in_ready and out_valid come only from registered occupancy, never from the other side.
  assign in_ready   = (occupancy != OCC_FULL);
  assign out_valid  = (occupancy != '0);
  assign push       = in_valid & in_ready & ~flush;
  assign pop        = out_valid & out_ready;
  assign rd_ptr_inc = rd_ptr + AW'(1);

  always_comb begin
    out_inst = RESET_INST;
    out_pc   = 32'h0;
    if (out_valid) begin
      out_inst = inst_mem[rd_ptr];
      out_pc   = pc_mem[rd_ptr];
    end
  end

  assign out_pc4 = out_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= in_inst;
      pc_mem[wr_ptr]   <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      // The head may still be taken by decode; everything behind it is dropped.
      rd_ptr    <= pop ? rd_ptr_inc : rd_ptr;
      wr_ptr    <= pop ? rd_ptr_inc : rd_ptr;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

`ifdef IF_ID_QUEUE_PERF_EN
  logic [16:0] drops_sum;

  // pop implies occupancy >= 1, so the subtraction cannot underflow.
  assign drops_sum = {1'b0, flush_drops} + 17'(occupancy) - 17'(pop)
                   + 17'(in_valid & in_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_drops  <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (flush)
        flush_drops <= drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
    end
  end
`endif

endmodule
